grover_measure: RTL and testbench
=================================

# grover_measure

Readout block at the consumer end of the Grover search engine's amplitude outputs. It snapshots the eight signed fixed-point amplitudes when the engine reports done, then serially squares and accumulates them. It reports the most probable basis state (argmax of amplitude²) with its probability weight, the total weight, and a hit flag against the searched target. It gives the engine a measurement stage feeding downstream control and LED/UART reporting.

## Interface
- num_bit, 3, index width; num_sample = 2**num_bit = 8 fixed
- fixedpoint_bit, 8, amplitude width (signed two's complement)
- lfsr_seed, 16'hACE1, LFSR reset value (random mode only; must be nonzero)

- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  driven by engine done; amplitudes stable while high
- meas_en  in  1  measurement request
- target_search  in  num_bit  searched index, compared to result
- i0..i7  in  fixedpoint_bit each, signed  amplitudes of states 0..7
- index  out  num_bit  measured state
- prob  out  16  square of selected amplitude, unsigned
- total  out  19  sum of all eight squares, unsigned
- valid  out  1  one-cycle pulse; index/prob/total/hit updated with it
- busy  out  1  high while not IDLE
- hit  out  1  index == target_search (target sampled at trigger)

## Operation
- FSM states: IDLE, SCAN, DRAW (DRAW exists only with macro).
- IDLE: trigger = in_valid & meas_en at a clock edge. On trigger, load the i0..i7 snapshot and target_search. Clear sample counter cnt, accumulator, and max registers. Go to SCAN.
- SCAN: one sample per cycle, cnt 0..7. sq = a[cnt]*a[cnt] as signed 8×8, stored as 16-bit unsigned. Max is 16384 for -128, so there is no overflow. acc += sq in 19 bits, no saturation needed.
- Max update only when sq > max_sq (strict). Ties resolve to lowest index. An all-zero input gives index 0, prob 0.
- On the cnt==7 edge without the macro: load the index/prob/total/hit registers, pulse valid, go to IDLE.
- Changes on in_valid, i0..i7 or target_search after the trigger are ignored (snapshot).
- meas_en held high with in_valid high retriggers back-to-back. A new trigger is accepted on the edge right after valid.
- Outputs hold their last result until the next valid or reset.
- Reset: synchronous. Any state goes to IDLE. index=0, prob=0, total=0, valid=0, busy=0, hit=0, LFSR=lfsr_seed. A measurement aborted by reset produces no valid.

## Timing
- Trigger edge T. SCAN edges T+1..T+8. valid is high in the cycle after edge T+8: 8 cycles deterministic.
- Random mode: DRAW edges T+9..T+16, then valid: 16 cycles.
- busy rises after edge T. It falls in the same cycle valid is high.
- The earliest retrigger edge is T+9 (deterministic) or T+17 (random).

## Configuration
- Macro: GROVER_MEASURE_RAND_EN.
- Undefined: deterministic argmax as above. No LFSR or DRAW logic.
- Defined: probabilistic measurement.
  - A 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, advances every non-reset cycle.
  - On the last SCAN edge: thr = (lfsr × total_final) >> 16, 19 bits.
  - DRAW makes a second pass over the snapshot with cnt 0..7 and running cumulative sum cum += sq.
  - The first index where cum > thr is selected. prob is that index's sq.
  - If total==0, select index 0 with prob 0.
  - Result registers load and valid pulses on the cnt==7 DRAW edge.
  - total and hit have the same meaning as in deterministic mode.

## Test plan
- i5=-60, others 10, target=5, meas_en+in_valid one cycle → valid 8 cycles later: index=5, prob=3600, total=4300, hit=1; busy high for exactly 8 cycles.
- i2=i6=50, others 0, target=6 → index=2, prob=2500, total=5000, hit=0 (lowest-index tie-break).
- All inputs 0 → valid pulses: index=0, prob=0, total=0. i7=-128, others 0 → index=7, prob=16384, total=16384.
- Trigger, then rst at SCAN cnt==4 → no valid. All outputs 0 the cycle after reset. A fresh trigger then completes normally in 8 cycles.
- Change i0..i7 and drop in_valid mid-SCAN → result matches the trigger-time snapshot. meas_en held high → valid every 9 cycles.
- With GROVER_MEASURE_RAND_EN, i3=-60, others 10, meas_en held for 2000 measurements → index 3 frequency 0.837±0.03, others about 0.023 each. Latency 16. All-zero input → index 0.

Source files
------------

// File: rtl/grover_measure.sv
// Grover readout: snapshots eight signed amplitudes, squares and accumulates them
// serially, and reports argmax, its weight, total weight and a target-hit flag.
// Defining GROVER_MEASURE_RAND_EN replaces argmax with an LFSR-driven weighted draw.
module grover_measure #(
  parameter int NUM_BIT        = 3,
  parameter int FIXEDPOINT_BIT = 8
`ifdef GROVER_MEASURE_RAND_EN
  , parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  input  logic                                   meas_en,
  input  logic [NUM_BIT-1:0]                     target_search,
  input  logic signed [FIXEDPOINT_BIT-1:0]       i0,
  input  logic signed [FIXEDPOINT_BIT-1:0]       i1,
  input  logic signed [FIXEDPOINT_BIT-1:0]       i2,
  input  logic signed [FIXEDPOINT_BIT-1:0]       i3,
  input  logic signed [FIXEDPOINT_BIT-1:0]       i4,
  input  logic signed [FIXEDPOINT_BIT-1:0]       i5,
  input  logic signed [FIXEDPOINT_BIT-1:0]       i6,
  input  logic signed [FIXEDPOINT_BIT-1:0]       i7,
  output logic [NUM_BIT-1:0]                     index,
  output logic [2*FIXEDPOINT_BIT-1:0]            prob,
  output logic [2*FIXEDPOINT_BIT+NUM_BIT-1:0]    total,
  output logic                                   valid,
  output logic                                   busy,
  output logic                                   hit
);

  localparam int SQ_W  = 2 * FIXEDPOINT_BIT;
  localparam int TOT_W = SQ_W + NUM_BIT;
  localparam logic [NUM_BIT-1:0] LAST_CNT = {NUM_BIT{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    SCAN
`ifdef GROVER_MEASURE_RAND_EN
    , DRAW
`endif
  } state_e;

  state_e state_q, state_d;

  logic signed [FIXEDPOINT_BIT-1:0] snap_q [8];
  logic [NUM_BIT-1:0] target_q;
  logic [NUM_BIT-1:0] cnt_q;
  logic [TOT_W-1:0]   acc_q;
  logic [SQ_W-1:0]    max_sq_q;
  logic [NUM_BIT-1:0] max_idx_q;

  logic [NUM_BIT-1:0] index_q;
  logic [SQ_W-1:0]    prob_q;
  logic [TOT_W-1:0]   total_q;
  logic               hit_q;
  logic               valid_q;

  logic trigger, last, load_snap, scan_en;
  logic signed [SQ_W-1:0] sq_s;
  logic [SQ_W-1:0]    sq;
  logic [TOT_W-1:0]   acc_sum;
  logic               max_upd;
  logic [SQ_W-1:0]    max_sq_nx;
  logic [NUM_BIT-1:0] max_idx_nx;

`ifdef GROVER_MEASURE_RAND_EN
  logic [15:0]        lfsr_q;
  logic [TOT_W-1:0]   thr_q, thr_d;
  logic [TOT_W-1:0]   cum_q, cum_sum;
  logic               found_q, draw_hit, draw_en;
  logic [NUM_BIT-1:0] sel_idx_q, sel_idx_nx;
  logic [SQ_W-1:0]    sel_prob_q, sel_prob_nx;
`endif

  assign trigger = in_valid & meas_en;
  assign last    = (cnt_q == LAST_CNT);

  // Self-multiplication of a signed value is never negative, so the low SQ_W
  // bits are the exact unsigned square (max 16384 for -128).
  assign sq_s       = snap_q[cnt_q] * snap_q[cnt_q];
  assign sq         = sq_s;
  assign acc_sum    = acc_q + TOT_W'(sq);
  assign max_upd    = (sq > max_sq_q);
  assign max_sq_nx  = max_upd ? sq    : max_sq_q;
  assign max_idx_nx = max_upd ? cnt_q : max_idx_q;

`ifdef GROVER_MEASURE_RAND_EN
  assign thr_d       = TOT_W'(({{TOT_W{1'b0}}, lfsr_q} * {16'h0000, acc_sum}) >> 16);
  assign cum_sum     = cum_q + TOT_W'(sq);
  assign draw_hit    = !found_q && (cum_sum > thr_q);
  assign sel_idx_nx  = draw_hit ? cnt_q : sel_idx_q;
  assign sel_prob_nx = draw_hit ? sq    : sel_prob_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (trigger) state_d = SCAN;
`ifdef GROVER_MEASURE_RAND_EN
      SCAN: if (last) state_d = DRAW;
      DRAW: if (last) state_d = IDLE;
`else
      SCAN: if (last) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    busy      = (state_q != IDLE);
    load_snap = (state_q == IDLE) && trigger;
    scan_en   = (state_q == SCAN);
`ifdef GROVER_MEASURE_RAND_EN
    draw_en   = (state_q == DRAW);
`endif
  end

  // NOTE: the snapshot is pure data, always written before it is read, so it
  // carries no reset and needs no reset fan-out.
  always_ff @(posedge clk) begin
    if (load_snap) begin
      snap_q[0] <= i0;
      snap_q[1] <= i1;
      snap_q[2] <= i2;
      snap_q[3] <= i3;
      snap_q[4] <= i4;
      snap_q[5] <= i5;
      snap_q[6] <= i6;
      snap_q[7] <= i7;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q  <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      max_sq_q  <= '0;
      max_idx_q <= '0;
      index_q   <= '0;
      prob_q    <= '0;
      total_q   <= '0;
      hit_q     <= 1'b0;
      valid_q   <= 1'b0;
`ifdef GROVER_MEASURE_RAND_EN
      thr_q      <= '0;
      cum_q      <= '0;
      found_q    <= 1'b0;
      sel_idx_q  <= '0;
      sel_prob_q <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (load_snap) begin
        target_q  <= target_search;
        cnt_q     <= '0;
        acc_q     <= '0;
        max_sq_q  <= '0;
        max_idx_q <= '0;
      end else if (scan_en) begin
        cnt_q     <= cnt_q + NUM_BIT'(1);
        acc_q     <= acc_sum;
        max_sq_q  <= max_sq_nx;
        max_idx_q <= max_idx_nx;
        if (last) begin
`ifdef GROVER_MEASURE_RAND_EN
          thr_q      <= thr_d;
          cum_q      <= '0;
          found_q    <= 1'b0;
          sel_idx_q  <= '0;
          sel_prob_q <= '0;
`else
          index_q <= max_idx_nx;
          prob_q  <= max_sq_nx;
          total_q <= acc_sum;
          hit_q   <= (max_idx_nx == target_q);
          valid_q <= 1'b1;
`endif
        end
      end
`ifdef GROVER_MEASURE_RAND_EN
      else if (draw_en) begin
        // Second pass: first index whose running cumulative weight exceeds thr.
        cnt_q <= cnt_q + NUM_BIT'(1);
        cum_q <= cum_sum;
        if (draw_hit) begin
          found_q    <= 1'b1;
          sel_idx_q  <= cnt_q;
          sel_prob_q <= sq;
        end
        if (last) begin
          index_q <= sel_idx_nx;
          prob_q  <= sel_prob_nx;
          total_q <= acc_q;
          hit_q   <= (sel_idx_nx == target_q);
          valid_q <= 1'b1;
        end
      end
`endif
    end
  end

`ifdef GROVER_MEASURE_RAND_EN
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running outside reset.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`endif

  assign index = index_q;
  assign prob  = prob_q;
  assign total = total_q;
  assign valid = valid_q;
  assign hit   = hit_q;

endmodule

// File: tb/tb_grover_measure.sv
// Directed bench for grover_measure in its default (deterministic argmax) build.
module tb_grover_measure;

  logic clk = 1'b0;
  logic rst, in_valid, meas_en;
  logic [2:0] target_search;
  logic signed [7:0] amp [8];
  logic [2:0]  index;
  logic [15:0] prob;
  logic [18:0] total;
  logic valid, busy, hit;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  grover_measure dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .meas_en(meas_en),
    .target_search(target_search),
    .i0(amp[0]), .i1(amp[1]), .i2(amp[2]), .i3(amp[3]),
    .i4(amp[4]), .i5(amp[5]), .i6(amp[6]), .i7(amp[7]),
    .index(index), .prob(prob), .total(total),
    .valid(valid), .busy(busy), .hit(hit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_amps(input int base, input int sel_a, input int val_a,
                          input int sel_b, input int val_b);
    for (int k = 0; k < 8; k++) amp[k] = 8'(base);
    if (sel_a >= 0) amp[sel_a] = 8'(val_a);
    if (sel_b >= 0) amp[sel_b] = 8'(val_b);
  endtask

  // Called at a negedge with amplitudes/target already driven. Pulses the
  // trigger for one edge and checks latency, busy width and the result.
  // With corrupt set, inputs are scrambled two cycles into the scan.
  task automatic measure(input string tag, input bit corrupt,
                         input int e_idx, input int e_prob, input int e_tot, input int e_hit);
    int  busy_cnt;
    int  lat;
    bit  got;
    busy_cnt = 0;
    lat = -1;
    got = 1'b0;
    in_valid = 1'b1;
    meas_en  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    meas_en  = 1'b0;
    for (int m = 0; m < 20 && !got; m++) begin
      if (valid) begin
        got = 1'b1;
        lat = m;
      end else begin
        if (busy) busy_cnt++;
        if (corrupt && m == 2) begin
          set_amps(0, 0, 100, -1, 0);
          target_search = 3'd0;
        end
        @(negedge clk);
      end
    end
    check({tag, ".valid_seen"}, 32'(got), 32'd1);
    check({tag, ".latency"},    32'(lat), 32'd8);
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd8);
    check({tag, ".busy_at_valid"}, 32'(busy), 32'd0);
    check({tag, ".index"}, 32'(index), 32'(e_idx));
    check({tag, ".prob"},  32'(prob),  32'(e_prob));
    check({tag, ".total"}, 32'(total), 32'(e_tot));
    check({tag, ".hit"},   32'(hit),   32'(e_hit));
  endtask

  initial begin
    int vpos [8];
    int nv;
    int seen;

    rst = 1'b1;
    in_valid = 1'b0;
    meas_en = 1'b0;
    target_search = 3'd0;
    set_amps(0, -1, 0, -1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset.index", 32'(index), 32'd0);
    check("reset.prob",  32'(prob),  32'd0);
    check("reset.total", 32'(total), 32'd0);
    check("reset.valid", 32'(valid), 32'd0);
    check("reset.busy",  32'(busy),  32'd0);
    check("reset.hit",   32'(hit),   32'd0);

    // Dominant negative amplitude at the target.
    set_amps(10, 5, -60, -1, 0);
    target_search = 3'd5;
    measure("peak5", 1'b0, 5, 3600, 4300, 1);
    repeat (3) @(negedge clk);
    check("hold.valid", 32'(valid), 32'd0);
    check("hold.prob",  32'(prob),  32'd3600);
    check("hold.index", 32'(index), 32'd5);

    // Equal peaks: lowest index wins, target at the other one.
    set_amps(0, 2, 50, 6, 50);
    target_search = 3'd6;
    measure("tie26", 1'b0, 2, 2500, 5000, 0);

    // All-zero input.
    set_amps(0, -1, 0, -1, 0);
    target_search = 3'd0;
    measure("zero", 1'b0, 0, 0, 0, 1);

    // Most negative amplitude, full-scale square.
    set_amps(0, 7, -128, -1, 0);
    target_search = 3'd7;
    measure("min7", 1'b0, 7, 16384, 16384, 1);

    // Abort by reset while scanning sample 4.
    set_amps(10, 5, -60, -1, 0);
    target_search = 3'd5;
    in_valid = 1'b1;
    meas_en  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    meas_en  = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.index", 32'(index), 32'd0);
    check("abort.prob",  32'(prob),  32'd0);
    check("abort.total", 32'(total), 32'd0);
    check("abort.busy",  32'(busy),  32'd0);
    check("abort.hit",   32'(hit),   32'd0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (valid) seen++;
      @(negedge clk);
    end
    check("abort.no_valid", 32'(seen), 32'd0);
    set_amps(0, 2, 50, 6, 50);
    target_search = 3'd2;
    measure("after_abort", 1'b0, 2, 2500, 5000, 1);

    // Inputs change and in_valid drops mid-scan: snapshot must win.
    set_amps(10, 5, -60, -1, 0);
    target_search = 3'd5;
    measure("snapshot", 1'b1, 5, 3600, 4300, 1);

    // meas_en and in_valid held high: back-to-back every 9 cycles.
    set_amps(0, 2, 50, 6, 50);
    target_search = 3'd6;
    in_valid = 1'b1;
    meas_en  = 1'b1;
    nv = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid && nv < 8) begin
        vpos[nv] = c;
        nv++;
      end
    end
    in_valid = 1'b0;
    meas_en  = 1'b0;
    check("b2b.count", 32'(nv), 32'd4);
    if (nv > 0) check("b2b.first", 32'(vpos[0]), 32'd8);
    for (int k = 1; k < nv; k++) check("b2b.period", 32'(vpos[k] - vpos[k-1]), 32'd9);
    check("b2b.index", 32'(index), 32'd2);
    check("b2b.total", 32'(total), 32'd5000);
    repeat (12) @(negedge clk);
    check("b2b.idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
